arb_req_client: RTL
===================

// Module: arb_req_client
// PURPOSE
// - Requester-side front end for one port of the shared-memory weighted round-robin arbiter.
// - Buffers local commands in a FIFO and raises arb_req_o while work is pending.
// - On arb_grant_i, issues the head command on the shared memory bus and waits for mem_ack_i or a timeout.
// - Returns a response to the local master, then dequeues.
// - One instance sits per arbiter port: arb_req_o drives req_i[n], arb_grant_i takes grant_o[n].
// PARAMETERS
// - ADDR_W      32   address width
// - DATA_W      32   data width
// - FIFO_DEPTH  4    command FIFO entries; power of 2, >=2
// - TIMEOUT     255  max cycles in WAIT_RSP before error completion; 1..2^TO_W-1
// - TO_W        8    timeout counter width
// PORTS
// - clk_i            in   1       clock; all logic on posedge
// - rst_i            in   1       reset; asynchronous, active-high
// - cmd_valid_i      in   1       local command valid
// - cmd_ready_o      out  1       FIFO not full; push = cmd_valid_i & cmd_ready_o
// - cmd_we_i         in   1       1 = write, 0 = read
// - cmd_addr_i       in   ADDR_W  command address
// - cmd_wdata_i      in   DATA_W  write data
// - rsp_valid_o      out  1       one-cycle completion pulse
// - rsp_rdata_o      out  DATA_W  read data; 0 for writes and errors
// - rsp_err_o        out  1       completion was a timeout
// - arb_req_o        out  1       request to arbiter; registered
// - arb_grant_i      in   1       grant from arbiter; registered one-hot bit
// - mem_valid_o      out  1       bus command strobe, exactly one cycle per issue
// - mem_we_o         out  1       bus write enable
// - mem_addr_o       out  ADDR_W  bus address
// - mem_wdata_o      out  DATA_W  bus write data
// - mem_ack_i        in   1       bus completion
// - mem_rdata_i      in   DATA_W  bus read data; valid with mem_ack_i
// BEHAVIOUR
// - Reset (async):
//   - State goes to IDLE; FIFO is emptied (contents discarded).
//   - Timeout counter is cleared.
//   - All outputs 0 except cmd_ready_o = 1.
// - FSM states: IDLE, REQ, ISSUE, WAIT_RSP.
// - IDLE:
//   - arb_req_o = 0.
//   - FIFO non-empty -> REQ.
//   - Push in cycle N gives arb_req_o = 1 in cycle N+1.
// - REQ:
//   - arb_req_o = 1, held until arb_grant_i is sampled high.
//   - On arb_grant_i = 1 -> ISSUE.
// - ISSUE (one cycle):
//   - mem_valid_o = 1; mem_we/addr/wdata_o = FIFO head.
//   - arb_req_o = 0; next state WAIT_RSP; timeout counter cleared.
//   - mem_* fields hold their values until the next ISSUE; only mem_valid_o pulses.
// - WAIT_RSP:
//   - Counter increments each cycle without mem_ack_i.
//   - mem_ack_i = 1: pop head; rsp_valid_o = 1 next cycle; rsp_rdata_o = mem_rdata_i for reads, 0 for writes; rsp_err_o = 0.
//   - Counter == TIMEOUT without ack: pop head; rsp_valid_o = 1 next cycle with rsp_err_o = 1, rsp_rdata_o = 0.
//   - Ack and timeout in the same cycle: ack wins (err = 0).
//   - Exit: FIFO still non-empty after pop -> REQ, else IDLE.
// - Ignored inputs:
//   - arb_grant_i outside REQ (stale grants from the arbiter's credit reuse).
//   - mem_ack_i outside WAIT_RSP.
// - FIFO:
//   - Pointers are FIFO_DEPTH-wrap with an extra wrap bit for full/empty.
//   - Push and pop in the same cycle are both allowed; count is unchanged.
//   - cmd_ready_o = !full (combinational from count). Push while full is not possible.
//   - The head entry is never overwritten while in ISSUE or WAIT_RSP.
// - At most one outstanding bus transaction. Commands complete in push order.
// - Reset mid-transaction abandons the command. A later mem_ack_i is ignored (state is IDLE).
// TESTING
// - T1: Single read addr 0x10; grant 2 cycles after arb_req_o; ack 3 cycles after mem_valid_o with rdata 0xCAFE -> one mem_valid_o pulse with addr 0x10; rsp_valid_o with rdata 0xCAFE, err 0.
// - T2: Push 4 writes back-to-back (DEPTH 4) -> cmd_ready_o = 0 after the 4th. Each ack frees one slot; 4 in-order completions, addrs 0,4,8,C on the bus.
// - T3: Stale arb_grant_i pulses during WAIT_RSP and IDLE -> no extra mem_valid_o; state unaffected.
// - T4: TIMEOUT = 5, no ack -> rsp_valid_o with rsp_err_o = 1 exactly 5 cycles into WAIT_RSP. Late ack afterwards is ignored.
// - T5: Push during WAIT_RSP in the same cycle as ack (simultaneous push/pop) -> count unchanged; next state REQ; arb_req_o = 1 the following cycle.
// - T6: Assert rst_i mid-WAIT_RSP with 2 queued -> outputs 0 immediately, cmd_ready_o = 1; subsequent ack produces no rsp_valid_o.

Source files
------------

// File: rtl/arb_req_client_if.sv
// Bundle of the local command/response, arbiter and shared memory bus signals for one
// arbiter port. The client drives through "master"; its environment uses "slave".
interface arb_req_client_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_we_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              arb_req_o;
  logic              arb_grant_i;
  logic              mem_valid_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i,
    input  arb_grant_i, mem_ack_i, mem_rdata_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output arb_req_o, mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i,
    output arb_grant_i, mem_ack_i, mem_rdata_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  arb_req_o, mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/arb_req_client.sv
// Requester front end for one weighted round-robin arbiter port: queues local commands,
// requests the shared memory bus, issues one command at a time and returns its completion.
module arb_req_client #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  arb_req_client_if.master  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {IDLE, REQ, ISSUE, WAIT_RSP} state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   fifo_q [FIFO_DEPTH];
  logic [EW-1:0]   head;
  logic [AW:0]     wptr_q, rptr_q, count, count_n;
  logic            push, pop, full, empty;
  logic            ack_hit, to_hit;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign count   = wptr_q - rptr_q;
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (wptr_q == rptr_q);
  assign push    = bus.cmd_valid_i & ~full;
  assign head    = fifo_q[rptr_q[AW-1:0]];
  assign bus.cmd_ready_o = ~full;

  // An ack in the final allowed cycle still beats the timeout.
  assign ack_hit = (state_q == WAIT_RSP) & bus.mem_ack_i;
  assign to_hit  = (state_q == WAIT_RSP) & ~bus.mem_ack_i & (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign pop     = ack_hit | to_hit;
  assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    unique case (state_q)
      IDLE:     if (!empty || push) state_d = REQ;
      REQ:      if (bus.arb_grant_i) state_d = ISSUE;
      ISSUE: begin
        state_d  = WAIT_RSP;
        to_cnt_d = '0;
      end
      WAIT_RSP: begin
        if (pop) state_d = (count_n != '0) ? REQ : IDLE;
        else     to_cnt_d = to_cnt_q + 1'b1;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q[AW-1:0]] <= {bus.cmd_we_i, bus.cmd_addr_i, bus.cmd_wdata_i};
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.arb_req_o   <= 1'b0;
      bus.mem_valid_o <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_err_o   <= 1'b0;
      bus.rsp_rdata_o <= '0;
    end else begin
      bus.arb_req_o   <= (state_d == REQ);
      bus.mem_valid_o <= (state_d == ISSUE);
      if (state_q == REQ && bus.arb_grant_i)
        {bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} <= head;
      bus.rsp_valid_o <= pop;
      bus.rsp_err_o   <= to_hit;
      bus.rsp_rdata_o <= (ack_hit && !bus.mem_we_o) ? bus.mem_rdata_i : '0;
    end
  end
endmodule
